// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and width defaults for the fetch controller
package fetch_pkg;
  localparam int PC_W_DEF = 16;
  localparam int REG_W_DEF = 3;
  typedef enum logic [1:0] {
    RUN = 2'b00,
    REDIRECT = 2'b01,
    HALTED = 2'b10
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: drives fetch PC-select and pipeline flushes for redirects, halts and load-use stalls
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic [PC_W-1:0]  id_PC,
  input  logic [PC_W-1:0]  if_PC,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             halt,
  output logic [PC_W-1:0]  haltPC,
  output logic             jorb,
  output logic [PC_W-1:0]  newPC,
  output logic             ldStall,
  output logic [PC_W-1:0]  ldStallPC,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state, state_nxt;
  logic [PC_W-1:0] hpc_q;
  logic hazard, halted, take_br, take_halt, take_ld;
  always_comb begin
    hazard = ex_valid && ex_memread && id_valid &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    halted = state == HALTED;
    take_br = !rst && !halted && ex_br_taken;
    take_halt = !rst && state == RUN && !ex_br_taken && id_valid && id_halt;
    take_ld = !rst && state == RUN && !ex_br_taken && !(id_valid && id_halt) && hazard;
    halt = !rst && (halted || take_halt);
    haltPC = rst ? '0 : halted ? hpc_q : take_halt ? id_PC : if_PC;
    jorb = take_br;
    newPC = rst ? '0 : take_br ? ex_target : if_PC;
    ldStall = take_ld;
    ldStallPC = rst ? '0 : if_PC;
    flush_ifid = halt || take_br;
    flush_idex = take_br || take_ld;
    state_nxt = take_br ? REDIRECT : (halted || take_halt) ? HALTED : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      hpc_q <= '0;
    end else begin
      state <= state_nxt;
      if (take_halt) hpc_q <= id_PC;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(take_ld), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(take_br), .count(flush_cnt));
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Pipeline-front-end controller that sequences the fetch stage's PC-select inputs (halt/haltPC, jorb/newPC, ldStall/ldStallPC) and the IF/ID and ID/EX flush controls. It detects load-use hazards, applies redirects from branches resolved in EX, and handles the HALT instruction. It sits between decode/execute and fetch. It guarantees that at most one of halt, jorb and ldStall is asserted in any cycle, and it keeps saturating stall and flush event counters for debug.

Parameters:
PC_W, 16, PC and target width
REG_W, 3, register specifier width
CNT_W, 16, width of event counters

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_W  ID source register 1
id_rt  in  REG_W  ID source register 2
id_uses_rs  in  1  ID instruction reads id_rs
id_uses_rt  in  1  ID instruction reads id_rt
id_halt  in  1  ID instruction is HALT
id_PC  in  PC_W  PC of the ID instruction
if_PC  in  PC_W  current fetch PC
ex_valid  in  1  EX stage holds a real instruction
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination register
ex_br_taken  in  1  EX resolved a taken branch or jump
ex_target  in  PC_W  redirect target
halt  out  1  to fetch halt
haltPC  out  PC_W  to fetch haltPC
jorb  out  1  to fetch jorb
newPC  out  PC_W  to fetch newPC
ldStall  out  1  to fetch ldStall
ldStallPC  out  PC_W  to fetch ldStallPC
flush_ifid  out  1  squash the IF/ID register contents
flush_idex  out  1  insert a bubble into ID/EX
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- State register: RUN, REDIRECT, HALTED. Reset sets state=RUN, all flag outputs 0, PC outputs 0, counters 0.
- The state register and counters are registered. The flag outputs are combinational from state and inputs, so fetch sees them in the same cycle.
- hazard = ex_valid & ex_memread & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- RUN, priority order is branch > halt > hazard:
  - ex_br_taken: jorb=1, newPC=ex_target, flush_ifid=1, flush_idex=1, flush_cnt++; next state REDIRECT.
  - else id_valid & id_halt: halt=1, haltPC=id_PC, flush_ifid=1; next state HALTED.
  - else hazard: ldStall=1, ldStallPC=if_PC, flush_idex=1, stall_cnt++; stay in RUN.
- REDIRECT, one cycle: ID holds a squashed instruction, so hazard and id_halt are ignored. A new ex_br_taken is impossible because EX holds a bubble; if it is asserted anyway, it is treated as in RUN. Next state RUN.
- HALTED: halt=1 and haltPC hold the captured HALT PC; flush_ifid=1 every cycle; jorb=0, ldStall=0; counters frozen. Only rst exits this state.
- Exclusivity: halt, jorb and ldStall are never high together (an assertion is required in the bench).
- When no flag is active, newPC, ldStallPC and the combinational haltPC equal if_PC. Their values are don't-care while the corresponding flag is 0.
- Counters saturate at all-ones and do not wrap.
- rst asserted in any state: next cycle is RUN with cleared counters; a captured HALT PC is discarded.
- A back-to-back load-use on the same instruction cannot recur, because the bubble clears ex_valid. A second, independent hazard in the next cycle stalls again.

Decomposition:
- Shared package fetch_pkg: state encoding constants (RUN=2'b00, REDIRECT=2'b01, HALTED=2'b10) and the PC_W/REG_W defaults.
- One sub-module: sat_counter (CNT_W, inc, clk, rst, count), instantiated twice.
- The hazard compare stays inline.

Test Plan:
- Load-use: ex_valid=1, ex_memread=1, ex_rd=3; id_rs=3, id_uses_rs=1; if_PC=0x0010 -> ldStall=1, ldStallPC=0x0010, flush_idex=1 for exactly 1 cycle; stall_cnt=1.
- Redirect: ex_br_taken=1, ex_target=0x0040 with a coincident hazard -> jorb=1, newPC=0x0040, ldStall=0, both flushes=1; next cycle a hazard pattern on the ID inputs produces no ldStall; flush_cnt=1.
- Halt: id_halt=1, id_PC=0x0022 -> halt=1, haltPC=0x0022 that cycle and every cycle after; a later ex_br_taken=1 produces no jorb.
- Halt vs branch: id_halt=1 and ex_br_taken=1 together -> jorb=1, halt=0; state REDIRECT; the next cycle's id_halt is ignored.
- Saturation: 0xFFFF+3 hazard cycles -> stall_cnt=0xFFFF.
- Reset in HALTED: assert rst for 1 cycle -> halt=0, counters=0, state RUN; a hazard the following cycle stalls normally.
